// File: rtl/filter_stream_tx_pkg.sv
// Shared definitions for the filter stream transmitter: FSM states,
// data_id encodings and the coefficient-count derivation.
package filter_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_COEF = 3'd1,
    S_GAP  = 3'd2,
    S_PIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic ID_COF = 1'b1;
  localparam logic ID_PIX = 1'b0;

  // Number of coefficients for a square mask of the given side.
  function automatic int calc_taps(input int mask_width);
    return mask_width * mask_width;
  endfunction

endpackage

// File: rtl/filter_stream_tx_if.sv
// Stream bundle between the pixel source, the transmitter and the filter.
//
// Handshakes: the upstream pixel channel transfers a word on every rising
// clock edge where pix_in_valid && pix_in_ready; pix_in_ready never depends
// combinationally on pix_in_valid. The filter-side channel has no back
// pressure: each cycle with data_in_valid=1 is exactly one beat, data_id
// tells coefficient (1) from pixel (0), and data_in holds its last value
// while data_in_valid=0.
interface filter_stream_tx_if #(
  parameter int DATA_BIT   = 15,
  parameter int DATA_IDBIT = 1
) ();
  logic                  pix_in_valid;
  logic [DATA_BIT-1:0]   pix_in;
  logic                  pix_in_ready;
  logic                  data_in_valid;
  logic [DATA_BIT-1:0]   data_in;
  logic [DATA_IDBIT-1:0] data_id;

  // Transmitter side.
  modport master (
    input  pix_in_valid, pix_in,
    output pix_in_ready, data_in_valid, data_in, data_id
  );

  // Environment side: pixel source and filter sink.
  modport slave (
    output pix_in_valid, pix_in,
    input  pix_in_ready, data_in_valid, data_in, data_id
  );
endinterface

// File: rtl/fstx_cof_bank.sv
// Coefficient register file: TAPS words, one write port, one
// combinational read port, cleared by reset.
module fstx_cof_bank #(
  parameter int TAPS     = 49,
  parameter int DATA_BIT = 15,
  parameter int ADDR_BIT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_BIT-1:0] wr_addr,
  input  logic [DATA_BIT-1:0] wr_data,
  input  logic [ADDR_BIT-1:0] rd_addr,
  output logic [DATA_BIT-1:0] rd_data
);

  logic [DATA_BIT-1:0] mem_q [TAPS];
  logic [DATA_BIT-1:0] mem_d [TAPS];

  // Next contents: single write, out-of-range addresses never land.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_addr < ADDR_BIT'(TAPS))) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/filter_stream_tx.sv
// Filter stream transmitter: on start, sends all coefficients to the filter
// (data_id=1), optionally idles for GAP_CYCLES, then forwards one frame of
// pixels (data_id=0) and pulses done.
// Optional feature macro: FILTER_TX_GAP_EN enables the GAP idle phase.
module filter_stream_tx
  import filter_pkg::*;
#(
  parameter int DATA_BIT   = 15,
  parameter int DATA_IDBIT = 1,
  parameter int ROW_WIDTH  = 100,
  parameter int COL_WIDTH  = 100,
  parameter int MASK_WIDTH = 7,
  parameter int GAP_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset_in,
  input  logic                   cof_wr_en,
  input  logic [5:0]             cof_wr_addr,
  input  logic [DATA_BIT-1:0]    cof_wr_data,
  input  logic                   start,
  filter_stream_tx_if.master     bus,
  output logic                   busy,
  output logic                   done,
  output state_e                 state_dbg
);

  localparam int         TAPS      = calc_taps(MASK_WIDTH);
  localparam logic [5:0] COEF_LAST = 6'(TAPS - 1);
  localparam logic [13:0] PIX_LAST = 14'(ROW_WIDTH * COL_WIDTH - 1);

  state_e                state_q, state_d;
  logic [5:0]            coef_idx_q, coef_idx_d;
  logic [13:0]           pix_cnt_q, pix_cnt_d;
  logic                  dv_q, dv_d;
  logic [DATA_BIT-1:0]   data_q, data_d;
  logic [DATA_IDBIT-1:0] id_q, id_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cof_we;
  logic [DATA_BIT-1:0]   cof_rd;

`ifdef FILTER_TX_GAP_EN
  logic [15:0]           gap_cnt_q, gap_cnt_d;
`else
  logic                  unused_gap;
  assign unused_gap = ^GAP_CYCLES;
`endif

  // Coefficients may only change while no frame is in flight.
  assign cof_we = cof_wr_en && (state_q == S_IDLE) && (cof_wr_addr < 6'(TAPS));

  fstx_cof_bank #(
    .TAPS     (TAPS),
    .DATA_BIT (DATA_BIT),
    .ADDR_BIT (6)
  ) u_cof_bank (
    .clk     (clk),
    .rst     (reset_in),
    .wr_en   (cof_we),
    .wr_addr (cof_wr_addr),
    .wr_data (cof_wr_data),
    .rd_addr (coef_idx_q),
    .rd_data (cof_rd)
  );

  // Next state, counters and registered stream outputs.
  always_comb begin
    state_d    = state_q;
    coef_idx_d = coef_idx_q;
    pix_cnt_d  = pix_cnt_q;
    dv_d       = 1'b0;
    data_d     = data_q;
    id_d       = DATA_IDBIT'(ID_PIX);
`ifdef FILTER_TX_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_COEF;
          coef_idx_d = '0;
        end
      end
      S_COEF: begin
        dv_d   = 1'b1;
        data_d = cof_rd;
        id_d   = DATA_IDBIT'(ID_COF);
        if (coef_idx_q == COEF_LAST) begin
          coef_idx_d = '0;
`ifdef FILTER_TX_GAP_EN
          gap_cnt_d  = '0;
          state_d    = (GAP_CYCLES > 0) ? S_GAP : S_PIX;
`else
          state_d    = S_PIX;
`endif
        end else begin
          coef_idx_d = coef_idx_q + 6'd1;
        end
      end
`ifdef FILTER_TX_GAP_EN
      S_GAP: begin
        if (gap_cnt_q == 16'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = S_PIX;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
`endif
      S_PIX: begin
        if (bus.pix_in_valid) begin
          dv_d   = 1'b1;
          data_d = bus.pix_in;
          if (pix_cnt_q == PIX_LAST) begin
            pix_cnt_d = '0;
            state_d   = S_DONE;
          end else begin
            pix_cnt_d = pix_cnt_q + 14'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // busy covers the done cycle itself and drops right after it.
    done_d = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE) || done_d;
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      coef_idx_q <= '0;
      pix_cnt_q  <= '0;
      dv_q       <= 1'b0;
      data_q     <= '0;
      id_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      coef_idx_q <= coef_idx_d;
      pix_cnt_q  <= pix_cnt_d;
      dv_q       <= dv_d;
      data_q     <= data_d;
      id_q       <= id_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef FILTER_TX_GAP_EN
  // Idle-phase counter.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

  // Ready is a pure function of state, so it drops the cycle after the last pixel.
  assign bus.pix_in_ready  = (state_q == S_PIX);
  assign bus.data_in_valid = dv_q;
  assign bus.data_in       = data_q;
  assign bus.data_id       = id_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_filter_stream_tx.sv
// Bench for filter_stream_tx: directed frames, scoreboard queue of expected
// {data_id, data_in} beats, negedge monitor, final summary.
module tb_filter_stream_tx;
  import filter_pkg::*;

  localparam int DW = 15;
  localparam int NPIX = 10000;
`ifdef FILTER_TX_GAP_EN
  localparam int GAP = 8;
`else
  localparam int GAP = 0;
`endif

  logic          clk;
  logic          reset_in;
  logic          cof_wr_en;
  logic [5:0]    cof_wr_addr;
  logic [DW-1:0] cof_wr_data;
  logic          start;
  logic          busy;
  logic          done;
  state_e        state_dbg;

  filter_stream_tx_if #(.DATA_BIT(DW), .DATA_IDBIT(1)) bus ();

  filter_stream_tx dut (
    .clk         (clk),
    .reset_in    (reset_in),
    .cof_wr_en   (cof_wr_en),
    .cof_wr_addr (cof_wr_addr),
    .cof_wr_data (cof_wr_data),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard state.
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] exp_coef[49];
  logic [DW-1:0] last_data = '0;
  int n_tests = 0;
  int n_fail  = 0;
  int beats = 0;
  int first_beat_cyc = -1;
  int last_coef_cyc = -1;
  int first_pix_cyc = -1;
  int last_beat_cyc = -1;
  int done_cnt = 0;
  int done_cyc = -1;
  int exp_first_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: pops one expectation per beat, checks hold/id while idle.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (reset_in) begin
      last_data = '0;
    end else begin
      if (bus.data_in_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got id=%0d data=%0d expected no beat", bus.data_id, bus.data_in);
        end else begin
          e = exp_q.pop_front();
          if ({bus.data_id, bus.data_in} !== e) begin
            n_fail++;
            $display("FAIL beat: got id=%0d data=%0d expected id=%0d data=%0d",
                     bus.data_id, bus.data_in, e[DW], e[DW-1:0]);
          end
        end
        beats++;
        last_beat_cyc = cyc;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        if (bus.data_id == 1'b1) last_coef_cyc = cyc;
        else if (first_pix_cyc < 0) first_pix_cyc = cyc;
        last_data = bus.data_in;
      end else begin
        n_tests++;
        if (bus.data_in !== last_data || bus.data_id !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_hold: got id=%0d data=%0d expected id=0 data=%0d",
                   bus.data_id, bus.data_in, last_data);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic write_coef(input logic [5:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    cof_wr_en = 1'b1;
    cof_wr_addr = addr;
    cof_wr_data = data;
    @(negedge clk);
    cof_wr_en = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    beats = 0;
    first_beat_cyc = -1;
    last_coef_cyc = -1;
    first_pix_cyc = -1;
    start = 1'b1;
    exp_first_cyc = cyc + 2;
    for (int i = 0; i < 49; i++) exp_q.push_back({1'b1, exp_coef[i]});
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_pixels(input int n, input bit toggle, input int glitch_at, input int k);
    int i;
    int g;
    bit ph;
    i = 0;
    g = 0;
    ph = 1'b1;
    while (i < n && g < 30000) begin
      @(negedge clk);
      g++;
      start = 1'b0;
      cof_wr_en = 1'b0;
      bus.pix_in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      bus.pix_in = DW'(i * k);
      if (bus.pix_in_ready && i == glitch_at) begin
        start = 1'b1;
        cof_wr_en = 1'b1;
        cof_wr_addr = 6'd3;
        cof_wr_data = DW'(77);
      end
      #1;
      if (bus.pix_in_valid && bus.pix_in_ready) begin
        exp_q.push_back({1'b0, bus.pix_in});
        i++;
      end
    end
    check("pix_all_accepted", i, n);
    @(negedge clk);
    bus.pix_in_valid = 1'b0;
    start = 1'b0;
    cof_wr_en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int g;
    g = 0;
    #1;
    while (!done && g < budget) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("done_seen", done, 1);
    check("done_after_last_beat", done_cyc - last_beat_cyc, 1);
    check("busy_during_done", busy, 1);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.data_in_valid, 0);
    check({tag, "_data"}, bus.data_in, 0);
    check({tag, "_id"}, bus.data_id, 0);
    check({tag, "_ready"}, bus.pix_in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, state_dbg, S_IDLE);
  endtask

  // Directed sequence.
  initial begin
    int d0;
    reset_in = 1'b1;
    cof_wr_en = 1'b0;
    cof_wr_addr = '0;
    cof_wr_data = '0;
    start = 1'b0;
    bus.pix_in_valid = 1'b0;
    bus.pix_in = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    #2 reset_in = 1'b0;

    // Frame A: all coefficients 334, pixels 0..9999 back to back.
    for (int i = 0; i < 49; i++) begin
      write_coef(6'(i), DW'(334));
      exp_coef[i] = DW'(334);
    end
    write_coef(6'd60, DW'(999));
    d0 = done_cnt;
    start_frame();
    send_pixels(NPIX, 1'b0, -1, 1);
    wait_done(200);
    check("a_first_coef_latency", first_beat_cyc, exp_first_cyc);
    check("a_gap_len", first_pix_cyc - last_coef_cyc, GAP + 1);
    check("a_beats", beats, 49 + NPIX);
    check("a_done_count", done_cnt - d0, 1);

    // Frame B: coefficients = index, valid toggling, start/write glitch mid-frame.
    for (int i = 0; i < 49; i++) begin
      write_coef(6'(i), DW'(i));
      exp_coef[i] = DW'(i);
    end
    d0 = done_cnt;
    start_frame();
    send_pixels(NPIX, 1'b1, 100, 37);
    wait_done(200);
    check("b_beats", beats, 49 + NPIX);
    check("b_done_count", done_cnt - d0, 1);

    // Frame C: coef[3] must still be 3; reset after pixel 500.
    write_coef(6'd60, DW'(999));
    d0 = done_cnt;
    start_frame();
    send_pixels(500, 1'b0, -1, 5);
    drain(20);
    check("c_beats", beats, 49 + 500);
    check("c_busy_before_reset", busy, 1);
    #2 reset_in = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    #2 reset_in = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    #1;
    check("c_no_done", done_cnt - d0, 0);
    check("c_no_restart", busy, 0);

    // Frame D: coefficients cleared by reset.
    for (int i = 0; i < 49; i++) exp_coef[i] = '0;
    start_frame();
    send_pixels(20, 1'b0, -1, 3);
    drain(20);
    check("d_beats", beats, 49 + 20);
    #2 reset_in = 1'b1;
    @(negedge clk);
    #2 reset_in = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/filter_stream_tx.md
FILTER_STREAM_TX -- requirements
Module: filter_stream_tx

Interface
REQ-001 SHALL have parameter DATA_BIT, default 15, width of pixel/coefficient word.
REQ-002 SHALL have parameter DATA_IDBIT, default 1, width of data_id.
REQ-003 SHALL have parameters ROW_WIDTH and COL_WIDTH, both default 100, image dimensions in pixels.
REQ-004 SHALL have parameter MASK_WIDTH, default 7; TAPS = MASK_WIDTH*MASK_WIDTH = 49 coefficients.
REQ-005 SHALL have parameter GAP_CYCLES, default 8, idle cycles between coefficient and pixel phases.
REQ-006 SHALL have one clock; reset is asynchronous and active-high: clk in 1, rising-edge clock.
REQ-007 reset_in  in  1  asynchronous active-high reset.
REQ-008 cof_wr_en  in  1  coefficient write strobe.
REQ-009 cof_wr_addr  in  6  coefficient index, 0..TAPS-1.
REQ-010 cof_wr_data  in  DATA_BIT  coefficient value.
REQ-011 start  in  1  begin one frame transfer.
REQ-012 pix_in_valid  in  1  upstream pixel valid.
REQ-013 pix_in  in  DATA_BIT  upstream pixel value.
REQ-014 pix_in_ready  out  1  upstream pixel accept.
REQ-015 data_in_valid  out  1  filter-side beat valid.
REQ-016 data_in  out  DATA_BIT  filter-side beat value.
REQ-017 data_id  out  DATA_IDBIT  1 = coefficient, 0 = pixel.
REQ-018 busy  out  1  high from start acceptance until done pulse; done  out  1  one-cycle end-of-frame pulse.

Function
REQ-019 SHALL implement FSM IDLE -> COEF -> GAP -> PIX -> DONE -> IDLE.
REQ-020 IDLE: start=1 SHALL move to COEF; start in any other state SHALL be ignored.
REQ-021 COEF: SHALL emit coef[0..TAPS-1] on consecutive cycles, data_id=1, data_in_valid=1, with no bubbles; first beat registered one cycle after the start edge.
REQ-022 After beat TAPS-1, SHALL enter GAP, holding data_in_valid=0 for exactly GAP_CYCLES cycles, then enter PIX.
REQ-023 PIX: pix_in_ready SHALL be 1; each cycle with pix_in_valid&&pix_in_ready SHALL produce, next cycle, data_in_valid=1, data_id=0, data_in=pix_in; no valid means data_in_valid=0 that cycle.
REQ-024 SHALL count accepted pixels (14-bit counter); on accepting pixel ROW_WIDTH*COL_WIDTH, pix_in_ready SHALL drop the following cycle and the FSM SHALL enter DONE.
REQ-025 DONE: done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE.
REQ-026 cof_wr_en SHALL update coef[cof_wr_addr] only in IDLE and only if cof_wr_addr<TAPS; otherwise the write SHALL be dropped.
REQ-027 data_in SHALL hold last value when data_in_valid=0; data_id SHALL be 0 outside COEF.

Reset
REQ-028 reset_in=1 SHALL asynchronously force IDLE, all counters 0, all coefficients 0, and data_in_valid, data_in, data_id, pix_in_ready, busy, done to 0.
REQ-029 reset mid-frame SHALL abort the frame with no done pulse; first post-reset frame requires fresh start.

Configuration
REQ-030 With macro FILTER_TX_GAP_EN defined, GAP state and GAP_CYCLES SHALL be active; without it, PIX SHALL follow the last coefficient beat directly and GAP_CYCLES SHALL be ignored.

Structure
REQ-031 Shared package filter_pkg SHALL hold state enum, ID_COF=1, ID_PIX=0, and TAPS derivation.
REQ-032 Coefficient storage SHALL be sub-module fstx_cof_bank (TAPS x DATA_BIT register file, one write and one read port).

Verification
REQ-033 Write all 49 coefs = 334, start -> 49 consecutive beats data_id=1 data_in=334, then 8 idle cycles (macro defined).
REQ-034 Coefs = index 0..48, continuous pixels 0..9999 -> pixel beats in order, done one cycle after beat 9999, busy low next cycle.
REQ-035 pix_in_valid toggling 1/0 -> data_in_valid mirrors with 1-cycle lag, total exactly 10000 pixel beats.
REQ-036 start and cof_wr_en (addr 3, data 77) pulsed mid-PIX -> no restart, coef[3] unchanged in next frame; addr 60 write in IDLE dropped.
REQ-037 reset_in asserted after pixel 500 -> outputs 0 immediately, no done; new frame emits coefficients 0.
REQ-038 Macro undefined -> first pixel beat possible the cycle after coefficient 48.
